// File: rtl/numpad_pkg.sv
// Shared scan codes, entry-buffer states and decoded key actions for the numpad entry engine.
package numpad_pkg;

  localparam logic [3:0] BLANK_BCD = 4'hF;

  localparam logic [8:0] SC_0        = 9'h070;
  localparam logic [8:0] SC_1        = 9'h069;
  localparam logic [8:0] SC_2        = 9'h072;
  localparam logic [8:0] SC_3        = 9'h07A;
  localparam logic [8:0] SC_4        = 9'h06B;
  localparam logic [8:0] SC_5        = 9'h073;
  localparam logic [8:0] SC_6        = 9'h074;
  localparam logic [8:0] SC_7        = 9'h06C;
  localparam logic [8:0] SC_8        = 9'h075;
  localparam logic [8:0] SC_9        = 9'h07D;
  localparam logic [8:0] SC_BKSP     = 9'h066;
  localparam logic [8:0] SC_ESC      = 9'h076;
  localparam logic [8:0] SC_ENTER    = 9'h05A;
  localparam logic [8:0] SC_KP_ENTER = 9'h15A;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    EDIT  = 2'd1,
    HOLD  = 2'd2
  } entry_state_t;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_DIGIT = 3'd1,
    ACT_BKSP  = 3'd2,
    ACT_ESC   = 3'd3,
    ACT_ENTER = 3'd4
  } key_act_t;

  // Returns {is_digit, value}.
  function automatic logic [4:0] scan_to_digit(input logic [8:0] code);
    logic [4:0] res;
    res = 5'd0;
    case (code)
      SC_0: res = {1'b1, 4'd0};
      SC_1: res = {1'b1, 4'd1};
      SC_2: res = {1'b1, 4'd2};
      SC_3: res = {1'b1, 4'd3};
      SC_4: res = {1'b1, 4'd4};
      SC_5: res = {1'b1, 4'd5};
      SC_6: res = {1'b1, 4'd6};
      SC_7: res = {1'b1, 4'd7};
      SC_8: res = {1'b1, 4'd8};
      SC_9: res = {1'b1, 4'd9};
      default: res = 5'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/numpad_entry_buffer_key_event_filter.sv
// Qualifies key events (enable, make/break, typematic repeat) and decodes them into a
// single-cycle action pulse; only the held-key tracking is registered.
module key_event_filter
  import numpad_pkg::*;
#(
  parameter int ACCEPT_REPEAT = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_key_valid,
  input  logic [8:0] i_last_change,
  input  logic       i_key_is_down,
  output logic       o_evt,
  output key_act_t   o_act,
  output logic [3:0] o_digit
);

  logic [8:0] r_held_code;
  logic       r_held;
  logic       w_make;
  logic       w_break;
  logic       w_repeat;
  logic       w_accept;
  logic [4:0] w_dig;
  key_act_t   w_act;

  assign w_make   = i_key_valid & i_key_is_down;
  assign w_break  = i_key_valid & ~i_key_is_down;
  assign w_repeat = r_held && (i_last_change == r_held_code);
  assign w_accept = i_en && w_make && ((ACCEPT_REPEAT != 0) || !w_repeat);
  assign w_dig    = scan_to_digit(i_last_change);

  always_comb begin
    w_act = ACT_NONE;
    if (w_dig[4])                                                   w_act = ACT_DIGIT;
    else if (i_last_change == SC_BKSP)                              w_act = ACT_BKSP;
    else if (i_last_change == SC_ESC)                               w_act = ACT_ESC;
    else if (i_last_change == SC_ENTER || i_last_change == SC_KP_ENTER) w_act = ACT_ENTER;
  end

  assign o_evt   = w_accept && (w_act != ACT_NONE);
  assign o_act   = w_act;
  assign o_digit = w_dig[3:0];

  // Breaks are tracked even while disabled so a key released during en=0 is not stuck held.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_held_code <= 9'd0;
      r_held      <= 1'b0;
    end else if (i_en && w_make) begin
      r_held_code <= i_last_change;
      r_held      <= 1'b1;
    end else if (w_break && w_repeat) begin
      r_held      <= 1'b0;
    end
  end

endmodule

// File: rtl/numpad_entry_buffer.sv
// Numeric entry engine: right-entered BCD buffer with backspace, clear and enter-to-commit,
// committed value handed off through a valid/ready handshake.
module numpad_entry_buffer
  import numpad_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int OVF_SHIFT     = 0,
  parameter int ACCEPT_REPEAT = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_key_valid,
  input  logic [8:0]            i_last_change,
  input  logic                  i_key_is_down,
  output logic [4*DIGITS-1:0]   o_disp_bcd,
  output logic [3:0]            o_len,
  output logic                  o_commit_valid,
  input  logic                  i_commit_ready,
  output logic [4*DIGITS-1:0]   o_commit_bcd,
  output logic [3:0]            o_commit_len,
  output logic                  o_overflow,
  output logic                  o_busy
);

  localparam logic [3:0]          LEN_MAX   = 4'(DIGITS);
  localparam logic [4*DIGITS-1:0] ALL_BLANK = {DIGITS{BLANK_BCD}};

  entry_state_t        r_state;
  logic [4*DIGITS-1:0] r_buf;
  logic [3:0]          r_len;
  logic                r_commit_valid;
  logic [4*DIGITS-1:0] r_commit_bcd;
  logic [3:0]          r_commit_len;
  logic                r_overflow;
  logic                r_busy;

  logic                w_evt;
  key_act_t            w_act;
  logic [3:0]          w_digit;
  logic [4*DIGITS+3:0] w_cat_up;
  logic [4*DIGITS+3:0] w_cat_dn;
  logic [4*DIGITS-1:0] w_shift_up;
  logic [4*DIGITS-1:0] w_shift_dn;

  key_event_filter #(.ACCEPT_REPEAT(ACCEPT_REPEAT)) u_filter (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_key_valid   (i_key_valid),
    .i_last_change (i_last_change),
    .i_key_is_down (i_key_is_down),
    .o_evt         (w_evt),
    .o_act         (w_act),
    .o_digit       (w_digit)
  );

  // Widened concatenations keep the shifts legal down to DIGITS=1.
  assign w_cat_up   = {r_buf, w_digit};
  assign w_cat_dn   = {BLANK_BCD, r_buf};
  assign w_shift_up = w_cat_up[4*DIGITS-1:0];
  assign w_shift_dn = w_cat_dn[4*DIGITS+3:4];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= EMPTY;
      r_buf          <= ALL_BLANK;
      r_len          <= 4'd0;
      r_commit_valid <= 1'b0;
      r_commit_bcd   <= ALL_BLANK;
      r_commit_len   <= 4'd0;
      r_overflow     <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      case (r_state)
        EMPTY: begin
          if (w_evt && w_act == ACT_DIGIT) begin
            r_buf   <= w_shift_up;
            r_len   <= 4'd1;
            r_state <= EDIT;
          end
        end
        EDIT: begin
          if (w_evt) begin
            case (w_act)
              ACT_DIGIT: begin
                if (r_len < LEN_MAX) begin
                  r_buf <= w_shift_up;
                  r_len <= r_len + 4'd1;
                end else begin
                  if (OVF_SHIFT != 0) r_buf <= w_shift_up;
                  r_overflow <= 1'b1;
                end
              end
              ACT_BKSP: begin
                r_buf <= w_shift_dn;
                r_len <= r_len - 4'd1;
                if (r_len == 4'd1) r_state <= EMPTY;
              end
              ACT_ESC: begin
                r_buf   <= ALL_BLANK;
                r_len   <= 4'd0;
                r_state <= EMPTY;
              end
              ACT_ENTER: begin
                r_commit_bcd   <= r_buf;
                r_commit_len   <= r_len;
                r_commit_valid <= 1'b1;
                r_buf          <= ALL_BLANK;
                r_len          <= 4'd0;
                r_busy         <= 1'b1;
                r_state        <= HOLD;
              end
              default: ;
            endcase
          end
        end
        HOLD: begin
          // A handshake and an ESC in the same cycle land in the same place; the value counts as delivered.
          if ((r_commit_valid && i_commit_ready) || (w_evt && w_act == ACT_ESC)) begin
            r_commit_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= EMPTY;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_disp_bcd     = r_buf;
  assign o_len          = r_len;
  assign o_commit_valid = r_commit_valid;
  assign o_commit_bcd   = r_commit_bcd;
  assign o_commit_len   = r_commit_len;
  assign o_overflow     = r_overflow;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_numpad_entry_buffer.sv
// Directed bench: three instances (drop-overflow, shift-overflow, accept-repeat) share one stimulus stream.
module tb_numpad_entry_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        key_valid = 1'b0;
  logic [8:0]  last_change = 9'd0;
  logic        key_is_down = 1'b0;
  logic        commit_ready = 1'b0;

  logic [15:0] disp0, disp1, disp2, cbcd0, cbcd1, cbcd2;
  logic [3:0]  len0, len1, len2, clen0, clen1, clen2;
  logic        cv0, cv1, cv2, ovf0, ovf1, ovf2, busy0, busy1, busy2;

  int n_tests = 0;
  int n_fail  = 0;
  int ovf_cnt0 = 0, ovf_cnt1 = 0, ovf_cnt2 = 0;
  int hold_cnt;

  logic [8:0] key_code [10] = '{9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
                                9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D};
  localparam logic [8:0] K_BKSP  = 9'h066;
  localparam logic [8:0] K_ESC   = 9'h076;
  localparam logic [8:0] K_ENTER = 9'h05A;

  always #5 clk = ~clk;

  numpad_entry_buffer #(.DIGITS(4), .OVF_SHIFT(0), .ACCEPT_REPEAT(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_key_valid(key_valid), .i_last_change(last_change),
    .i_key_is_down(key_is_down), .o_disp_bcd(disp0), .o_len(len0), .o_commit_valid(cv0),
    .i_commit_ready(commit_ready), .o_commit_bcd(cbcd0), .o_commit_len(clen0),
    .o_overflow(ovf0), .o_busy(busy0));

  numpad_entry_buffer #(.DIGITS(4), .OVF_SHIFT(1), .ACCEPT_REPEAT(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_key_valid(key_valid), .i_last_change(last_change),
    .i_key_is_down(key_is_down), .o_disp_bcd(disp1), .o_len(len1), .o_commit_valid(cv1),
    .i_commit_ready(commit_ready), .o_commit_bcd(cbcd1), .o_commit_len(clen1),
    .o_overflow(ovf1), .o_busy(busy1));

  numpad_entry_buffer #(.DIGITS(4), .OVF_SHIFT(0), .ACCEPT_REPEAT(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_key_valid(key_valid), .i_last_change(last_change),
    .i_key_is_down(key_is_down), .o_disp_bcd(disp2), .o_len(len2), .o_commit_valid(cv2),
    .i_commit_ready(commit_ready), .o_commit_bcd(cbcd2), .o_commit_len(clen2),
    .o_overflow(ovf2), .o_busy(busy2));

  always @(negedge clk) begin
    if (ovf0) ovf_cnt0++;
    if (ovf1) ovf_cnt1++;
    if (ovf2) ovf_cnt2++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic key_evt(input logic [8:0] code, input logic down);
    last_change = code;
    key_is_down = down;
    key_valid   = 1'b1;
    @(negedge clk);
    key_valid   = 1'b0;
  endtask

  task automatic press(input logic [8:0] code);
    key_evt(code, 1'b1);
    key_evt(code, 1'b0);
  endtask

  initial begin
    #12 rst = 1'b1;
    @(negedge clk);
    chk("rst_disp", 32'(disp0), 32'hFFFF);
    chk("rst_len", 32'(len0), 0);
    chk("rst_cv", 32'(cv0), 0);
    chk("rst_cbcd", 32'(cbcd0), 32'hFFFF);
    chk("rst_busy", 32'(busy0), 0);

    press(key_code[1]); press(key_code[2]); press(key_code[3]);
    chk("123_disp", 32'(disp0), 32'hF123);
    chk("123_len", 32'(len0), 3);
    press(K_ENTER);
    chk("ent_cbcd", 32'(cbcd0), 32'hF123);
    chk("ent_clen", 32'(clen0), 3);
    chk("ent_cv", 32'(cv0), 1);
    chk("ent_disp", 32'(disp0), 32'hFFFF);
    chk("ent_busy", 32'(busy0), 1);
    commit_ready = 1'b1;
    @(negedge clk);
    commit_ready = 1'b0;
    chk("hs_cv", 32'(cv0), 0);
    chk("hs_busy", 32'(busy0), 0);
    chk("hs_cbcd_kept", 32'(cbcd0), 32'hF123);

    ovf_cnt0 = 0; ovf_cnt1 = 0; ovf_cnt2 = 0;
    for (int d = 1; d <= 5; d++) press(key_code[d]);
    chk("ovf_drop_disp", 32'(disp0), 32'h1234);
    chk("ovf_drop_cnt", 32'(ovf_cnt0), 1);
    chk("ovf_shift_disp", 32'(disp1), 32'h2345);
    chk("ovf_shift_len", 32'(len1), 4);
    chk("ovf_shift_cnt", 32'(ovf_cnt1), 1);
    press(K_ESC);
    chk("esc_disp", 32'(disp0), 32'hFFFF);
    chk("esc_len", 32'(len1), 0);

    key_evt(key_code[7], 1'b1); key_evt(key_code[7], 1'b1); key_evt(key_code[7], 1'b1);
    chk("rep_off_disp", 32'(disp0), 32'hFFF7);
    chk("rep_off_len", 32'(len0), 1);
    chk("rep_on_disp", 32'(disp2), 32'hF777);
    chk("rep_on_len", 32'(len2), 3);
    key_evt(key_code[7], 1'b0);
    press(K_ESC);

    press(key_code[9]); press(key_code[8]); press(K_BKSP);
    chk("bk1_disp", 32'(disp0), 32'hFFF9);
    chk("bk1_len", 32'(len0), 1);
    press(K_BKSP);
    chk("bk2_disp", 32'(disp0), 32'hFFFF);
    chk("bk2_len", 32'(len0), 0);
    press(K_BKSP);
    chk("bk3_disp", 32'(disp0), 32'hFFFF);
    chk("bk3_len", 32'(len0), 0);
    chk("bk3_busy", 32'(busy0), 0);

    en = 1'b0;
    press(key_code[2]);
    chk("en0_disp", 32'(disp0), 32'hFFFF);
    en = 1'b1;
    press(key_code[0]); press(key_code[0]); press(key_code[7]);
    chk("lead0_disp", 32'(disp0), 32'hF007);
    chk("lead0_len", 32'(len0), 3);
    press(K_ESC);

    press(key_code[6]); press(K_ENTER);
    chk("hold_cbcd", 32'(cbcd0), 32'hFFF6);
    press(key_code[5]); press(K_ENTER);
    hold_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cv0) hold_cnt++;
    end
    chk("hold_cv_cycles", 32'(hold_cnt), 100);
    chk("hold_disp", 32'(disp0), 32'hFFFF);
    chk("hold_len", 32'(len0), 0);
    chk("hold_cbcd2", 32'(cbcd0), 32'hFFF6);
    chk("hold_clen", 32'(clen0), 1);
    commit_ready = 1'b1;
    key_evt(K_ESC, 1'b1);
    commit_ready = 1'b0;
    chk("escrdy_cv", 32'(cv0), 0);
    chk("escrdy_busy", 32'(busy0), 0);
    chk("escrdy_cbcd", 32'(cbcd0), 32'hFFF6);
    key_evt(K_ESC, 1'b0);
    press(key_code[2]);
    chk("after_hold_disp", 32'(disp0), 32'hFFF2);
    press(K_ESC);

    press(key_code[3]); press(K_ENTER);
    chk("pre_rst_cv", 32'(cv0), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_cv", 32'(cv0), 0);
    chk("arst_cbcd", 32'(cbcd0), 32'hFFFF);
    chk("arst_clen", 32'(clen0), 0);
    chk("arst_busy", 32'(busy0), 0);
    chk("arst_disp", 32'(disp0), 32'hFFFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    press(key_code[4]);
    chk("post_rst_disp", 32'(disp0), 32'hFFF4);
    chk("post_rst_len", 32'(len0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/numpad_entry_buffer.md
Name: numpad_entry_buffer

Overview:
- Parametrised numeric-entry engine between KeyboardDecoder and seven_segment: turns numpad key events into a right-entered, DIGITS-long BCD buffer with backspace, clear and enter-to-commit.
- Generalises the fixed 4-digit keypad display: digit count, overflow policy and typematic-repeat filtering are configurable.
- Committed numbers leave through a valid/ready handshake.

Parameters:
- DIGITS, 4, number of BCD digits held (1..8).
- OVF_SHIFT, 0, behaviour on a digit when full: 0 = drop the new digit and flag, 1 = discard the oldest digit and shift.
- ACCEPT_REPEAT, 0, 1 = typematic repeat makes of a held key are accepted; 0 = ignored.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  key events are processed only when 1.
- key_valid  in  1  one-cycle pulse from KeyboardDecoder.
- last_change  in  9  {extend, code} of the event.
- key_is_down  in  1  key_down[last_change] sampled with key_valid: 1 = make, 0 = break.
- disp_bcd  out  4*DIGITS  live buffer; digit 0 in [3:0]; empty positions = 4'hF (blank).
- len  out  4  digits currently entered, 0..DIGITS.
- commit_valid  out  1  committed value available.
- commit_ready  in  1  consumer accepts.
- commit_bcd  out  4*DIGITS  committed value, same packing as disp_bcd.
- commit_len  out  4  digit count of the committed value.
- overflow  out  1  one-cycle pulse when a digit is dropped (OVF_SHIFT=0) or the oldest digit is lost (OVF_SHIFT=1).
- busy  out  1  high while in HOLD.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = EMPTY.
  - disp_bcd all 4'hF.
  - len = 0.
  - commit_valid = 0; commit_bcd all 4'hF; commit_len = 0.
  - overflow = 0; busy = 0.
  - held flag cleared.
- Reset mid-HOLD discards the pending commit.
- Event acceptance: key_valid=1, en=1, key_is_down=1, and the event passes the repeat filter. All effects are registered and visible the cycle after the key_valid pulse.
- Repeat filter:
  - The block keeps held_code (9 bits) and held (1 bit).
  - A make sets held_code = last_change and held = 1.
  - A break with last_change == held_code clears held.
  - With ACCEPT_REPEAT=0, a make with held=1 and last_change == held_code is ignored.
  - Breaks never trigger actions.
- Key map:
  - Digits: 9'h070,069,072,07A,06B,073,074,06C,075,07D map to 0..9.
  - BKSP = 9'h066.
  - ESC = 9'h076.
  - ENTER = 9'h05A or 9'h15A.
  - All other codes are ignored.
- State EMPTY (len = 0):
  - Digit: digit 0 takes the new value, len = 1, go to EDIT.
  - BKSP, ENTER, ESC: no effect.
- State EDIT:
  - Digit with len < DIGITS: shift the buffer one position up (digit i+1 takes digit i), digit 0 takes the new value, len += 1.
  - Digit with len == DIGITS and OVF_SHIFT=1: shift; the top digit is lost; len unchanged; overflow pulses.
  - Digit with len == DIGITS and OVF_SHIFT=0: buffer unchanged; overflow pulses.
  - BKSP: shift down (digit i takes digit i+1), the top position becomes 4'hF, len -= 1. If len reaches 0, go to EMPTY.
  - ESC: buffer all 4'hF, len = 0, go to EMPTY.
  - ENTER: commit_bcd = disp_bcd, commit_len = len, commit_valid = 1, buffer cleared, len = 0, go to HOLD.
- Leading zeros are kept as real digits, e.g. "007" gives len = 3.
- State HOLD:
  - busy = 1.
  - Digit, BKSP and ENTER events are ignored and do not change the buffer.
  - ESC: commit_valid = 0, go to EMPTY (abort).
  - Handshake: commit_valid & commit_ready at a clock edge → next cycle commit_valid = 0, go to EMPTY. commit_bcd and commit_len keep their values until the next commit.
  - commit_ready while commit_valid = 0 has no effect.
  - If a handshake and an ESC event fall in the same cycle, the handshake wins (the value counts as delivered) and the state goes to EMPTY.
- en = 0: all events are ignored. The repeat filter still tracks breaks so that held does not stick. The handshake continues normally.
- commit_valid stays stable until handshake or ESC; commit_bcd does not change while commit_valid = 1.

Decomposition:
- Shared package numpad_pkg:
  - Scan-code constants for digit keys, BKSP, ESC, ENTER and KP_ENTER.
  - BLANK_BCD = 4'hF.
  - State enum {EMPTY, EDIT, HOLD}.
  - Function scan_to_digit returning {is_digit, value[3:0]}.
- One sub-module, key_event_filter: applies en, make/break qualification and the repeat filter, and outputs a one-cycle event pulse plus a decoded action. The top level holds the FSM, the shift buffer and the commit register.

Test Plan:
- Reset, then digit makes 1,2,3 with break between each → disp_bcd = 16'hF123, len = 3. Then ENTER → commit_bcd = 16'hF123, commit_len = 3, commit_valid = 1, disp_bcd = 16'hFFFF.
- DIGITS=4, OVF_SHIFT=0: keys 1,2,3,4,5 → disp_bcd = 16'h1234, one overflow pulse. Repeat with OVF_SHIFT=1 → 16'h2345, one overflow pulse.
- Key 7 make ×3 with no break, ACCEPT_REPEAT=0 → disp_bcd = 16'hFFF7, len = 1. Same stimulus with ACCEPT_REPEAT=1 → 16'hF777.
- Keys 9,8 then BKSP → 16'hFFF9. BKSP again → 16'hFFFF, len = 0, state EMPTY. A third BKSP → no change.
- In HOLD with commit_ready = 0: key 5 and ENTER → ignored, commit_valid stays 1 for 100 cycles. Then ESC and commit_ready in the same cycle → commit_valid = 0 next cycle, state EMPTY, commit_bcd retained.
- Drive rst = 0 asynchronously mid-cycle during HOLD → all outputs take reset values immediately. After release, key 4 → disp_bcd = 16'hFFF4.
